// File: rtl/psl_mmio_pkg.sv
// Shared types and widths for the PSL MMIO host-side initiator.
// Bit numbering follows the PSL convention: bit 0 is the MSB.
package psl_mmio_pkg;

  localparam int MMIO_AD_W   = 24;
  localparam int MMIO_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Command as presented on the ha_mm* bus (already aligned/replicated).
  typedef struct packed {
    logic                   cfg;
    logic                   rnw;
    logic                   dw;
    logic [0:MMIO_AD_W-1]   addr;
    logic [0:MMIO_DATA_W-1] data;
  } mmio_cmd_t;

  typedef struct packed {
    logic [0:MMIO_DATA_W-1] rdata;
    logic                   parity_err;
    logic                   timeout;
  } mmio_rsp_t;

  // A 32-bit write is replicated onto both halves of the doubleword bus.
  function automatic logic [0:MMIO_DATA_W-1] dup_word(input logic [0:31] word);
    return {word, word};
  endfunction

endpackage

// File: rtl/parity.sv
// Reduction parity with selectable sense: par = ^data ^ odd_parity.
module parity #(
  parameter int BITS = 64
) (
  input  logic [0:BITS-1] data,
  input  logic            odd_parity,
  output logic            par
);

  assign par = (^data) ^ odd_parity;

endmodule

// File: rtl/psl_mmio_master.sv
// Host-side MMIO initiator: turns a request/response port into single-beat
// ha_mm* transactions, checks read parity and abandons unanswered requests.
module psl_mmio_master
  import psl_mmio_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic                   ha_pclock,
  input  logic                   reset,
  input  logic                   odd_parity,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_cfg,
  input  logic                   req_rnw,
  input  logic                   req_dw,
  input  logic [0:MMIO_AD_W-1]   req_addr,
  input  logic [0:MMIO_DATA_W-1] req_wdata,
  output logic                   rsp_valid,
  output logic [0:MMIO_DATA_W-1] rsp_rdata,
  output logic                   rsp_parity_err,
  output logic                   rsp_timeout,
  output logic                   err_stray_ack,
  output logic                   ha_mmval,
  output logic                   ha_mmcfg,
  output logic                   ha_mmrnw,
  output logic                   ha_mmdw,
  output logic [0:MMIO_AD_W-1]   ha_mmad,
  output logic                   ha_mmadpar,
  output logic [0:MMIO_DATA_W-1] ha_mmdata,
  output logic                   ha_mmdatapar,
  input  logic                   ah_mmack,
  input  logic [0:MMIO_DATA_W-1] ah_mmdata,
  input  logic                   ah_mmdatapar
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e                 state;
  state_e                 next_state;
  mmio_cmd_t              cmd_q;
  mmio_cmd_t              cmd_d;
  mmio_rsp_t              rsp_q;
  mmio_rsp_t              rsp_d;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   timed_out;
  logic                   rd_par;
  logic [0:MMIO_DATA_W-1] rd_sel;
  logic                   ready_d;
  logic                   mmval_d;
  logic                   rsp_valid_d;

  assign timed_out = (wait_cnt >= CNT_LAST);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge ha_pclock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; ack wins over a timeout landing in the same cycle.
  // NOTE: each combinational block assigns a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (ah_mmack || timed_out) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // 32-bit reads return the half selected by the latched address LSB.
  always_comb begin
    rd_sel = ah_mmdata;
    if (!cmd_q.dw) begin
      rd_sel = {32'h0, (cmd_q.addr[MMIO_AD_W-1] ? ah_mmdata[32:63] : ah_mmdata[0:31])};
    end
  end

  // Output logic: next values of every registered output.
  always_comb begin
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    ready_d     = (next_state == IDLE);
    mmval_d     = (next_state == ISSUE);
    rsp_valid_d = (next_state == RESP);

    if (state == IDLE && req_valid) begin
      cmd_d.cfg  = req_cfg;
      cmd_d.rnw  = req_rnw;
      cmd_d.dw   = req_dw;
      cmd_d.addr = req_dw ? {req_addr[0:MMIO_AD_W-2], 1'b0} : req_addr;
      if (req_rnw)     cmd_d.data = '0;
      else if (req_dw) cmd_d.data = req_wdata;
      else             cmd_d.data = dup_word(req_wdata[32:63]);
    end

    if (state == WAIT) begin
      if (ah_mmack) begin
        rsp_d.rdata      = cmd_q.rnw ? rd_sel : '0;
        rsp_d.parity_err = cmd_q.rnw && (rd_par != ah_mmdatapar);
        rsp_d.timeout    = 1'b0;
      end else if (timed_out) begin
        rsp_d.rdata      = '0;
        rsp_d.parity_err = 1'b0;
        rsp_d.timeout    = 1'b1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      req_ready     <= 1'b1;
      ha_mmval      <= 1'b0;
      rsp_valid     <= 1'b0;
      cmd_q         <= '0;
      rsp_q         <= '0;
      wait_cnt      <= '0;
      err_stray_ack <= 1'b0;
    end else begin
      req_ready <= ready_d;
      ha_mmval  <= mmval_d;
      rsp_valid <= rsp_valid_d;
      cmd_q     <= cmd_d;
      rsp_q     <= rsp_d;

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // A late ack after a timeout lands in IDLE and is reported here too.
      if (ah_mmack && state != WAIT) err_stray_ack <= 1'b1;
    end
  end

  assign ha_mmcfg       = cmd_q.cfg;
  assign ha_mmrnw       = cmd_q.rnw;
  assign ha_mmdw        = cmd_q.dw;
  assign ha_mmad        = cmd_q.addr;
  assign ha_mmdata      = cmd_q.data;
  assign rsp_rdata      = rsp_q.rdata;
  assign rsp_parity_err = rsp_q.parity_err;
  assign rsp_timeout    = rsp_q.timeout;

  parity #(.BITS(MMIO_AD_W)) u_ad_par (
    .data       (ha_mmad),
    .odd_parity (odd_parity),
    .par        (ha_mmadpar)
  );

  parity #(.BITS(MMIO_DATA_W)) u_wd_par (
    .data       (ha_mmdata),
    .odd_parity (odd_parity),
    .par        (ha_mmdatapar)
  );

  parity #(.BITS(MMIO_DATA_W)) u_rd_par (
    .data       (ah_mmdata),
    .odd_parity (odd_parity),
    .par        (rd_par)
  );

endmodule

// File: tb/tb_psl_mmio_master.sv
// Directed bench for psl_mmio_master: a cycle-indexed expectation model plus
// one compare process, pinned by a few hand-computed literals.
module tb_psl_mmio_master;

  localparam int TMO   = 8;
  localparam int NEVER = 32'h7fff_ffff;

  typedef struct packed {
    logic        cfg;
    logic        rnw;
    logic        dw;
    logic [23:0] ad;
    logic [63:0] data;
  } cmd_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        perr;
    logic        tmo;
  } rsp_t;

  logic        ha_pclock = 1'b0;
  logic        reset;
  logic        odd_parity;
  logic        req_valid;
  logic        req_ready;
  logic        req_cfg;
  logic        req_rnw;
  logic        req_dw;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_parity_err;
  logic        rsp_timeout;
  logic        err_stray_ack;
  logic        ha_mmval;
  logic        ha_mmcfg;
  logic        ha_mmrnw;
  logic        ha_mmdw;
  logic [23:0] ha_mmad;
  logic        ha_mmadpar;
  logic [63:0] ha_mmdata;
  logic        ha_mmdatapar;
  logic        ah_mmack;
  logic [63:0] ah_mmdata;
  logic        ah_mmdatapar;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Expectation model, keyed by cycle number.
  cmd_t exp_cmd[int];
  rsp_t exp_rsp[int];
  bit   busy[int];
  bit   rst_chk[int];
  int   stray_on  = NEVER;
  int   stray_off = NEVER;

  // Last observations, used by the literal pins.
  logic [63:0] last_rdata;
  logic        last_perr;
  logic        last_tmo;
  int          last_rsp_cyc = -1;
  logic [63:0] last_mmdata;
  logic        last_mmdatapar;

  psl_mmio_master #(.TIMEOUT(TMO)) dut (
    .ha_pclock      (ha_pclock),
    .reset          (reset),
    .odd_parity     (odd_parity),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cfg        (req_cfg),
    .req_rnw        (req_rnw),
    .req_dw         (req_dw),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_parity_err (rsp_parity_err),
    .rsp_timeout    (rsp_timeout),
    .err_stray_ack  (err_stray_ack),
    .ha_mmval       (ha_mmval),
    .ha_mmcfg       (ha_mmcfg),
    .ha_mmrnw       (ha_mmrnw),
    .ha_mmdw        (ha_mmdw),
    .ha_mmad        (ha_mmad),
    .ha_mmadpar     (ha_mmadpar),
    .ha_mmdata      (ha_mmdata),
    .ha_mmdatapar   (ha_mmdatapar),
    .ah_mmack       (ah_mmack),
    .ah_mmdata      (ah_mmdata),
    .ah_mmdatapar   (ah_mmdatapar)
  );

  always #5 ha_pclock = ~ha_pclock;

  always @(posedge ha_pclock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // AFU config/MMIO space seen as doublewords.
  function automatic logic [63:0] afu_dw(input logic [23:0] addr);
    logic [23:0] base;
    base = {addr[23:1], 1'b0};
    case (base)
      24'h000000: return 64'h0000000100010010;
      24'h000040: return 64'h4D494E4944414544;
      default:    return {8'hA5, base, 8'h5A, base};
    endcase
  endfunction

  // Compare process: every cycle once the first reset has been applied.
  always @(negedge ha_pclock) begin
    int   k;
    cmd_t ec;
    rsp_t er;
    if (chk_en) begin
      k = cyc;
      check("req_ready", 128'(req_ready), 128'(!busy.exists(k)));
      check("ha_mmval", 128'(ha_mmval), 128'(exp_cmd.exists(k)));
      if (exp_cmd.exists(k) && ha_mmval) begin
        ec = exp_cmd[k];
        check("mm_cmd", 128'({ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmdata}), 128'(ec));
        check("ha_mmadpar", 128'(ha_mmadpar), 128'((^ec.ad) ^ odd_parity));
        check("ha_mmdatapar", 128'(ha_mmdatapar), 128'((^ec.data) ^ odd_parity));
        last_mmdata    = ha_mmdata;
        last_mmdatapar = ha_mmdatapar;
      end
      check("rsp_valid", 128'(rsp_valid), 128'(exp_rsp.exists(k)));
      if (exp_rsp.exists(k) && rsp_valid) begin
        er = exp_rsp[k];
        check("rsp", 128'({rsp_rdata, rsp_parity_err, rsp_timeout}), 128'(er));
        last_rdata   = rsp_rdata;
        last_perr    = rsp_parity_err;
        last_tmo     = rsp_timeout;
        last_rsp_cyc = k;
      end
      check("err_stray_ack", 128'(err_stray_ack), 128'(k >= stray_on && k < stray_off));
      if (rst_chk.exists(k)) begin
        check("rst_outputs", 128'({ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmdata}), 128'(0));
        check("rst_rsp", 128'({rsp_rdata, rsp_parity_err, rsp_timeout}), 128'(0));
        check("rst_parity", 128'({ha_mmadpar, ha_mmdatapar}), 128'({odd_parity, odd_parity}));
      end
    end
  end

  // One request: d = ack delay (1 = first WAIT cycle), 0 = never acked.
  task automatic run_txn(input logic cfg, input logic rnw, input logic dw,
                         input logic [23:0] addr, input logic [63:0] wdata,
                         input int d, input logic flip, output int acc);
    int          w;
    int          a;
    int          rc;
    cmd_t        e;
    rsp_t        r;
    logic [63:0] ack_data;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge ha_pclock);
      w++;
    end
    if (!req_ready) check("ready_wait", 128'(req_ready), 128'(1));
    a = cyc;
    e.cfg  = cfg;
    e.rnw  = rnw;
    e.dw   = dw;
    e.ad   = dw ? {addr[23:1], 1'b0} : addr;
    e.data = rnw ? 64'h0 : (dw ? wdata : {wdata[31:0], wdata[31:0]});
    exp_cmd[a + 1] = e;
    ack_data = rnw ? afu_dw(addr) : 64'h0123456789ABCDEF;
    if (d > 0 && d <= TMO) begin
      rc = a + 2 + d;
      if (!rnw)    r.rdata = 64'h0;
      else if (dw) r.rdata = ack_data;
      else         r.rdata = addr[0] ? {32'h0, ack_data[31:0]} : {32'h0, ack_data[63:32]};
      r.perr = rnw & flip;
      r.tmo  = 1'b0;
    end else begin
      rc = a + TMO + 2;
      r  = '0;
      r.tmo = 1'b1;
    end
    exp_rsp[rc] = r;
    for (int i = a + 1; i <= rc; i++) busy[i] = 1'b1;

    req_cfg   = cfg;
    req_rnw   = rnw;
    req_dw    = dw;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge ha_pclock);
    req_valid = 1'b0;
    req_wdata = 64'hBAD0BAD0BAD0BAD0;
    if (d > 0 && d <= TMO) begin
      repeat (d) @(negedge ha_pclock);
      ah_mmack     = 1'b1;
      ah_mmdata    = ack_data;
      ah_mmdatapar = (^ack_data) ^ odd_parity ^ flip;
      @(negedge ha_pclock);
      ah_mmack  = 1'b0;
      ah_mmdata = 64'hFFFF0000FFFF0000;
    end
    while (cyc <= rc) @(negedge ha_pclock);
    acc = a;
  endtask

  initial begin
    int a;
    reset        = 1'b1;
    odd_parity   = 1'b1;
    req_valid    = 1'b0;
    req_cfg      = 1'b0;
    req_rnw      = 1'b0;
    req_dw       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    ah_mmack     = 1'b0;
    ah_mmdata    = '0;
    ah_mmdatapar = 1'b0;

    repeat (2) @(negedge ha_pclock);
    rst_chk[cyc + 1] = 1'b1;
    rst_chk[cyc + 2] = 1'b1;
    chk_en = 1'b1;
    @(negedge ha_pclock);
    reset = 1'b0;
    repeat (2) @(negedge ha_pclock);

    // Config descriptor read, 64-bit.
    run_txn(1'b1, 1'b1, 1'b1, 24'h000000, 64'h0, 2, 1'b0, a);
    check("cfg_rd64_lit", 128'(last_rdata), 128'(64'h0000000100010010));
    check("cfg_rd64_perr_lit", 128'(last_perr), 128'(0));
    // 32-bit config reads, both halves; the first acks in the first WAIT cycle.
    run_txn(1'b1, 1'b1, 1'b0, 24'h000041, 64'h0, 1, 1'b0, a);
    check("cfg_rd32_hi_lit", 128'(last_rdata), 128'(64'h0000000044414544));
    check("min_period_lit", 128'(last_rsp_cyc), 128'(a + 3));
    run_txn(1'b1, 1'b1, 1'b0, 24'h000040, 64'h0, 4, 1'b0, a);
    check("cfg_rd32_lo_lit", 128'(last_rdata), 128'(64'h000000004D494E49));
    // 32-bit MMIO write replicates the word.
    run_txn(1'b0, 1'b0, 1'b0, 24'h000010, 64'h00000000C0000000, 3, 1'b0, a);
    check("wr32_data_lit", 128'(last_mmdata), 128'(64'hC0000000C0000000));
    check("wr32_par_lit", 128'(last_mmdatapar), 128'(1'b1));
    // Read with corrupted parity.
    run_txn(1'b0, 1'b1, 1'b1, 24'h000205, 64'h0, 2, 1'b1, a);
    check("rd_perr_lit", 128'(last_perr), 128'(1));
    // Write acked in the last WAIT cycle with bad parity: no error, no timeout.
    run_txn(1'b0, 1'b0, 1'b1, 24'h000123, 64'hFEDCBA9876543210, TMO, 1'b1, a);
    check("late_ack_ok_lit", 128'({last_tmo, last_perr}), 128'(0));

    odd_parity = 1'b0;
    run_txn(1'b0, 1'b1, 1'b0, 24'h000777, 64'h0, 5, 1'b0, a);
    run_txn(1'b0, 1'b0, 1'b1, 24'h0000AA, 64'h8000000000000001, 1, 1'b0, a);

    // Timeout, then a late ack in IDLE.
    run_txn(1'b0, 1'b1, 1'b1, 24'h000300, 64'h0, 0, 1'b0, a);
    check("tmo_cycle_lit", 128'(last_rsp_cyc), 128'(a + 10));
    check("tmo_flag_lit", 128'({last_tmo, last_rdata}), 128'({1'b1, 64'h0}));
    stray_on     = cyc + 1;
    ah_mmack     = 1'b1;
    ah_mmdata    = 64'h1111111111111111;
    ah_mmdatapar = 1'b0;
    @(negedge ha_pclock);
    ah_mmack = 1'b0;
    @(negedge ha_pclock);
    check("stray_lit", 128'(err_stray_ack), 128'(1));

    // Reset in the second WAIT cycle.
    odd_parity = 1'b1;
    a = cyc;
    exp_cmd[a + 1] = '{cfg: 1'b1, rnw: 1'b1, dw: 1'b1, ad: 24'h000008, data: 64'h0};
    for (int i = a + 1; i <= a + 3; i++) busy[i] = 1'b1;
    req_cfg   = 1'b1;
    req_rnw   = 1'b1;
    req_dw    = 1'b1;
    req_addr  = 24'h000009;
    req_valid = 1'b1;
    @(negedge ha_pclock);
    req_valid = 1'b0;
    repeat (2) @(negedge ha_pclock);
    reset     = 1'b1;
    stray_off = a + 4;
    rst_chk[a + 4] = 1'b1;
    rst_chk[a + 5] = 1'b1;
    @(negedge ha_pclock);
    reset = 1'b0;
    repeat (4) @(negedge ha_pclock);
    check("ready_after_rst_lit", 128'(req_ready), 128'(1));

    run_txn(1'b1, 1'b1, 1'b1, 24'h000000, 64'h0, 1, 1'b0, a);
    check("post_rst_rd_lit", 128'(last_rdata), 128'(64'h0000000100010010));

    repeat (2) @(negedge ha_pclock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, want < 10000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
